// File: rtl/sum_accumulator.sv
// Frame reducer: accumulates COUNT incoming sums into one total with a sticky overflow flag.
// Optional build macro SUM_ACC_SAT_EN selects saturating accumulation instead of modulo wrap.
module sum_accumulator #(
    parameter int SUM_W = 5,
    parameter int COUNT = 8,
    parameter int ACC_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SUM_W-1:0] in_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic             out_ovf
);

    localparam int CNT_W = (COUNT > 2) ? $clog2(COUNT) : 1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [ACC_W-1:0]   acc, acc_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               ovf, ovf_nxt;
    logic [ACC_W:0]     sum_ext;
    logic               accept;
    logic               last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
            ovf   <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        ovf_nxt   = ovf;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        last      = (cnt == CNT_W'(COUNT - 1));
        // Extra top bit captures the carry out of the accumulator width.
        sum_ext   = {1'b0, acc} + (ACC_W + 1)'(in_sum);

        case (state)
            ACCUM: begin
                in_ready = rst_n;
                accept   = in_valid & rst_n;
                if (accept) begin
                    ovf_nxt = ovf | sum_ext[ACC_W];
`ifdef SUM_ACC_SAT_EN
                    acc_nxt = (sum_ext[ACC_W] || ovf) ? '1 : sum_ext[ACC_W-1:0];
`else
                    acc_nxt = sum_ext[ACC_W-1:0];
`endif
                    if (last) begin
                        cnt_nxt   = '0;
                        state_nxt = HOLD;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    acc_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    assign out_total = acc;
    assign out_ovf   = ovf;

endmodule
